wb_rr_arbiter: RTL and testbench

- Round-robin Wishbone arbiter that shares one slave bus between NUM_MASTERS requesters, e.g. instruction/data ports of several CPU cores plus a DMA engine.
- Grants the whole bus to one master for the duration of its CYC, then moves on fairly to the next requester.
- A bus watchdog terminates any stalled access with an error, so a dead slave cannot hang the system.
- Sits between the CPU-side bus muxes and the shared memory/peripheral fabric.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_rr_arbiter_if.sv | 39 +++
 rtl/rr_pick.sv | 31 +++
 rtl/wb_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_wb_rr_arbiter.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the round-robin Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned WB_ADR_W = 32;
    localparam int unsigned WB_DAT_W = 32;
    localparam int unsigned WB_SEL_W = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusy  = 2'd1,
        StAbort = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_rr_arbiter_if.sv
// Bundle of the master-side and slave-side Wishbone signals around the arbiter.
// The 'master' modport is the arbiter's view: it masters the shared slave bus.
// The 'slave' modport is the environment: the requesting masters plus the slave.
interface wb_rr_arbiter_if
#(
    parameter int unsigned NUM_MASTERS = 4
);
    import wb_arb_pkg::*;

    logic [NUM_MASTERS-1:0]          m_cyc;
    logic [NUM_MASTERS-1:0]          m_stb;
    logic [NUM_MASTERS-1:0]          m_we;
    logic [WB_SEL_W*NUM_MASTERS-1:0] m_sel;
    logic [WB_ADR_W*NUM_MASTERS-1:0] m_adr;
    logic [WB_DAT_W*NUM_MASTERS-1:0] m_dat_o;
    logic [WB_DAT_W-1:0]             m_dat_i;
    logic [NUM_MASTERS-1:0]          m_ack;
    logic [NUM_MASTERS-1:0]          m_err;

    logic                            s_cyc;
    logic                            s_stb;
    logic                            s_we;
    logic [WB_SEL_W-1:0]             s_sel;
    logic [WB_ADR_W-1:0]             s_adr;
    logic [WB_DAT_W-1:0]             s_dat_o;
    logic [WB_DAT_W-1:0]             s_dat_i;
    logic                            s_ack;

    modport master (
        input  m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_o, s_dat_i, s_ack,
        output m_dat_i, m_ack, m_err, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o
    );

    modport slave (
        output m_cyc, m_stb, m_we, m_sel, m_adr, m_dat_o, s_dat_i, s_ack,
        input  m_dat_i, m_ack, m_err, s_cyc, s_stb, s_we, s_sel, s_adr, s_dat_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: first set request bit searching
// upward from (last + 1) mod NUM_MASTERS, wrapping round.
module rr_pick
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned IDX_W       = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       last,
    output logic [IDX_W-1:0]       winner,
    output logic                   valid
);

    // Walk the rotated order from far to near so the nearest requester wins.
    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = |req;
        for (int unsigned i = NUM_MASTERS; i >= 1; i--) begin
            idx = 32'(last) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (req[IDX_W'(idx)]) begin
                winner = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter with a bus watchdog. One master owns the slave
// bus for the whole of its CYC; a stalled strobe is terminated with ERR.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned TO_W        = 16
) (
    input  logic                   sys_clk,
    input  logic                   resetcpu,
    wb_rr_arbiter_if.master        bus,
    output logic [NUM_MASTERS-1:0] grant,
    output logic                   timeout_evt
);

    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);

    arb_state_e             state_q;
    logic [NUM_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]       gidx_q;
    logic [IDX_W-1:0]       last_q;
    logic [TO_W-1:0]        wd_q;

    logic [IDX_W-1:0]       pick_idx;
    logic                   pick_valid;
    logic                   busy;
    logic                   g_cyc;
    logic                   g_stb;
    logic                   wd_fire;

    rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_pick (
        .req    (bus.m_cyc),
        .last   (last_q),
        .winner (pick_idx),
        .valid  (pick_valid)
    );

    assign busy  = (state_q == StBusy);
    assign g_cyc = bus.m_cyc[gidx_q];
    assign g_stb = bus.m_stb[gidx_q];

    // A same-cycle ACK beats the watchdog, so s_ack gates the fire condition.
    assign wd_fire = busy && g_cyc && g_stb && !bus.s_ack && (wd_q == TO_W'(TIMEOUT));

    assign grant       = grant_q;
    assign timeout_evt = wd_fire;

    // FSM, grant/last registers and watchdog counter.
    always_ff @(posedge sys_clk or negedge resetcpu) begin
        if (!resetcpu) begin
            state_q <= StIdle;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= IDX_W'(NUM_MASTERS - 1);
            wd_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    wd_q <= '0;
                    if (pick_valid) begin
                        state_q <= StBusy;
                        gidx_q  <= pick_idx;
                        last_q  <= pick_idx;
                        grant_q <= {{(NUM_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
                    end
                end
                StBusy: begin
                    if (!g_cyc) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                        wd_q    <= '0;
                    end else if (wd_fire) begin
                        state_q <= StAbort;
                        wd_q    <= '0;
                    end else if (g_stb && !bus.s_ack) begin
                        wd_q <= wd_q + 1'b1;
                    end else begin
                        wd_q <= '0;
                    end
                end
                StAbort: begin
                    wd_q <= '0;
                    if (!g_cyc) begin
                        state_q <= StIdle;
                        grant_q <= '0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    grant_q <= '0;
                    wd_q    <= '0;
                end
            endcase
        end
    end

    // Slave-side mux and master-side ACK/ERR steering from the registered grant.
    always_comb begin
        bus.m_dat_i = bus.s_dat_i;
        bus.m_ack   = '0;
        bus.m_err   = '0;
        bus.s_cyc   = 1'b0;
        bus.s_stb   = 1'b0;
        bus.s_we    = 1'b0;
        bus.s_sel   = '0;
        bus.s_adr   = '0;
        bus.s_dat_o = '0;
        if (busy) begin
            bus.s_cyc          = g_cyc;
            bus.s_stb          = g_stb;
            bus.s_we           = bus.m_we[gidx_q];
            bus.s_sel          = bus.m_sel[WB_SEL_W*32'(gidx_q) +: WB_SEL_W];
            bus.s_adr          = bus.m_adr[WB_ADR_W*32'(gidx_q) +: WB_ADR_W];
            bus.s_dat_o        = bus.m_dat_o[WB_DAT_W*32'(gidx_q) +: WB_DAT_W];
            bus.m_ack[gidx_q]  = bus.s_ack & g_stb;
            bus.m_err[gidx_q]  = wd_fire;
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: reset, fairness, single access, hold,
// watchdog timeout, ACK/timeout race and asynchronous reset mid-burst.
module tb_wb_rr_arbiter;

    logic       sys_clk;
    logic       resetcpu;
    logic [3:0] grant;
    logic       timeout_evt;

    int n_cmp = 0;
    int n_err = 0;

    wb_rr_arbiter_if #(.NUM_MASTERS(4)) bus ();

    wb_rr_arbiter #(
        .NUM_MASTERS (4),
        .TIMEOUT     (8),
        .TO_W        (16)
    ) dut (
        .sys_clk     (sys_clk),
        .resetcpu    (resetcpu),
        .bus         (bus),
        .grant       (grant),
        .timeout_evt (timeout_evt)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive(input int i, input logic cyc, input logic stb, input logic we,
                         input logic [3:0] sel, input logic [31:0] adr, input logic [31:0] dat);
        bus.m_cyc[i]            = cyc;
        bus.m_stb[i]            = stb;
        bus.m_we[i]             = we;
        bus.m_sel[4*i +: 4]     = sel;
        bus.m_adr[32*i +: 32]   = adr;
        bus.m_dat_o[32*i +: 32] = dat;
    endtask

    initial begin
        resetcpu    = 1'b0;
        bus.m_cyc   = '0;
        bus.m_stb   = '0;
        bus.m_we    = '0;
        bus.m_sel   = '0;
        bus.m_adr   = '0;
        bus.m_dat_o = '0;
        bus.s_dat_i = '0;
        bus.s_ack   = 1'b0;

        // Reset state
        #3;
        chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_s_cyc", 32'(bus.s_cyc), 32'h0);
        chk("rst_s_stb", 32'(bus.s_stb), 32'h0);
        chk("rst_ack", 32'(bus.m_ack), 32'h0);
        chk("rst_err", 32'(bus.m_err), 32'h0);
        chk("rst_evt", 32'(timeout_evt), 32'h0);
        tick();
        resetcpu = 1'b1;
        tick();

        // Fairness: everyone requests, expected order 0,1,2,3,0
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b1, 1'b1, 1'b0, 4'hF, 32'h4000_0000 + 32'(i), 32'h0);
        end
        settle();
        chk("fair_pre_s_cyc", 32'(bus.s_cyc), 32'h0);
        for (int k = 0; k < 5; k++) begin
            int e;
            e = k % 4;
            tick();
            settle();
            chk("fair_grant", 32'(grant), 32'h1 << e);
            chk("fair_adr", bus.s_adr, 32'h4000_0000 + 32'(e));
            bus.s_ack = 1'b1;
            settle();
            chk("fair_ack", 32'(bus.m_ack), 32'h1 << e);
            tick();
            bus.s_ack    = 1'b0;
            bus.m_cyc[e] = 1'b0;
            tick();
            settle();
            chk("fair_dead", 32'(grant), 32'h0);
            if (k < 4) bus.m_cyc[e] = 1'b1;
        end
        bus.m_cyc = '0;
        bus.m_stb = '0;
        tick();

        // Single master read on master 2
        drive(0, 1'b0, 1'b0, 1'b1, 4'h1, 32'h0000_0A00, 32'h0);
        drive(2, 1'b1, 1'b1, 1'b0, 4'hF, 32'h1000_0020, 32'h0);
        settle();
        chk("single_pre_cyc", 32'(bus.s_cyc), 32'h0);
        tick();
        settle();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_s_cyc", 32'(bus.s_cyc), 32'h1);
        chk("single_adr", bus.s_adr, 32'h1000_0020);
        chk("single_noack", 32'(bus.m_ack), 32'h0);
        bus.s_ack   = 1'b1;
        bus.s_dat_i = 32'hDEAD_BEEF;
        settle();
        chk("single_ack", 32'(bus.m_ack), 32'h4);
        chk("single_dat", bus.m_dat_i, 32'hDEAD_BEEF);
        tick();
        bus.s_ack = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 4'hF, 32'h1000_0020, 32'h0);
        tick();
        settle();
        chk("single_release", 32'(grant), 32'h0);

        // Hold: master 1 owns the bus for 10 accesses while master 3 waits
        drive(1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h2000_0004, 32'hCAFE_0001);
        tick();
        drive(3, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h3333_3333);
        settle();
        chk("hold_grant0", 32'(grant), 32'h2);
        chk("hold_we", 32'(bus.s_we), 32'h1);
        chk("hold_sel", 32'(bus.s_sel), 32'h3);
        chk("hold_dat_o", bus.s_dat_o, 32'hCAFE_0001);
        chk("hold_adr", bus.s_adr, 32'h2000_0004);
        for (int k = 0; k < 10; k++) begin
            bus.s_ack = 1'b1;
            settle();
            chk("hold_grant", 32'(grant), 32'h2);
            chk("hold_ack", 32'(bus.m_ack), 32'h2);
            tick();
        end
        bus.s_ack = 1'b0;
        drive(1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        tick();
        settle();
        chk("hold_dead", 32'(grant), 32'h0);
        tick();
        settle();
        chk("hold_m3_grant", 32'(grant), 32'h8);

        // Timeout: master 3 strobes, slave never answers
        chk("to_evt_c0", 32'(timeout_evt), 32'h0);
        for (int k = 1; k < 8; k++) begin
            tick();
            settle();
            chk("to_evt_early", 32'(timeout_evt), 32'h0);
        end
        tick();
        settle();
        chk("to_err", 32'(bus.m_err), 32'h8);
        chk("to_evt", 32'(timeout_evt), 32'h1);
        tick();
        settle();
        chk("to_abort_cyc", 32'(bus.s_cyc), 32'h0);
        chk("to_abort_evt", 32'(timeout_evt), 32'h0);
        chk("to_abort_err", 32'(bus.m_err), 32'h0);
        bus.s_ack = 1'b1;
        settle();
        chk("to_abort_ack", 32'(bus.m_ack), 32'h0);
        bus.s_ack = 1'b0;
        tick();
        settle();
        chk("to_abort_hold", 32'(bus.s_cyc), 32'h0);
        drive(3, 1'b0, 1'b0, 1'b0, 4'hF, 32'h3000_0000, 32'h3333_3333);
        tick();
        settle();
        chk("to_idle", 32'(grant), 32'h0);

        // Race: ACK in the cycle the counter reaches TIMEOUT
        drive(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h5000_0000, 32'h0);
        tick();
        settle();
        chk("race_grant", 32'(grant), 32'h1);
        for (int k = 1; k <= 8; k++) tick();
        bus.s_ack = 1'b1;
        settle();
        chk("race_evt", 32'(timeout_evt), 32'h0);
        chk("race_err", 32'(bus.m_err), 32'h0);
        chk("race_ack", 32'(bus.m_ack), 32'h1);
        tick();
        bus.s_ack = 1'b0;
        settle();
        chk("race_still_busy", 32'(bus.s_cyc), 32'h1);
        chk("race_evt_after", 32'(timeout_evt), 32'h0);
        drive(0, 1'b0, 1'b0, 1'b0, 4'hF, 32'h5000_0000, 32'h0);
        tick();

        // Asynchronous reset mid-burst with master 3 granted
        drive(3, 1'b1, 1'b1, 1'b0, 4'hF, 32'h3000_0000, 32'h0);
        tick();
        settle();
        chk("rst_mid_grant", 32'(grant), 32'h8);
        resetcpu = 1'b0;
        #1;
        chk("rst_async_grant", 32'(grant), 32'h0);
        chk("rst_async_cyc", 32'(bus.s_cyc), 32'h0);
        for (int i = 0; i < 4; i++) begin
            drive(i, 1'b1, 1'b1, 1'b0, 4'hF, 32'h6000_0000 + 32'(i), 32'h0);
        end
        tick();
        tick();
        resetcpu = 1'b1;
        tick();
        settle();
        chk("rst_first_winner", 32'(grant), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
